// File: rtl/mreza_upravljac.sv
// mreza_upravljac
// Sequencer for a small two-hidden-neuron classifier. One shared hidden-neuron
// datapath is run twice (neuron 0, then neuron 1). The two results are packed
// into uzorak for the combinational output neuron. Its probability is then
// captured and compared against PRAG to decide "mine / no mine".
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   start_valid/ready     request handshake; ready only while idle
//   neu_start, neu_sel    one-cycle start pulse and neuron index to the datapath
//   neu_done, neu_izlaz   datapath completion strobe and 40-bit result
//   uzorak                {h0, h1} presented to the output neuron
//   izlaz                 output-neuron probability (combinational from uzorak)
//   rez_valid/ready       result handshake
//   vjerojatnost          captured probability (0 on timeout)
//   mina                  vjerojatnost >= PRAG
//   greska                result produced by a hidden-neuron timeout
//   broj_uzoraka          count of accepted results, wraps at 16 bits
//
// BROJ_INIT is the reset value of broj_uzoraka. It defaults to 0 and exists
// so the wrap-around path can be exercised without tens of thousands of
// transactions.
//
// state    | meaning
// IDLE     | ready for a new sample
// H0_START | pulse neu_start for hidden neuron 0
// H0_WAIT  | wait for neu_done of neuron 0, with timeout
// H1_START | pulse neu_start for hidden neuron 1
// H1_WAIT  | wait for neu_done of neuron 1, with timeout
// OUT_WAIT | give the output neuron OUT_LAT cycles to settle
// RESULT   | hold result until the consumer accepts it

module mreza_upravljac #(
    parameter int          OUT_LAT   = 2,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] PRAG      = 16'h8000,
    parameter logic [15:0] BROJ_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    output logic        neu_start,
    output logic        neu_sel,
    input  logic        neu_done,
    input  logic [39:0] neu_izlaz,
    output logic [79:0] uzorak,
    input  logic [15:0] izlaz,
    output logic        rez_valid,
    input  logic        rez_ready,
    output logic [15:0] vjerojatnost,
    output logic        mina,
    output logic        greska,
    output logic [15:0] broj_uzoraka
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        H0_START = 3'd1,
        H0_WAIT  = 3'd2,
        H1_START = 3'd3,
        H1_WAIT  = 3'd4,
        OUT_WAIT = 3'd5,
        RESULT   = 3'd6
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [15:0] OUT_LAT_C = 16'(OUT_LAT);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;        // wait-cycle / settle-cycle index, counts from 1
    logic        h1_reached; // RESULT keeps neu_sel=0 if neuron 1 was never started
    logic        wait_hit;
    logic        out_hit;

    assign wait_hit = (cnt == TIMEOUT_C);
    assign out_hit  = (cnt == OUT_LAT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        neu_start   = 1'b0;
        neu_sel     = 1'b0;
        rez_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = H0_START;
            end
            H0_START: begin
                neu_start  = 1'b1;
                state_next = H0_WAIT;
            end
            H0_WAIT: begin
                // A done arriving on the timeout cycle still counts as success.
                if (neu_done)      state_next = H1_START;
                else if (wait_hit) state_next = RESULT;
            end
            H1_START: begin
                neu_start  = 1'b1;
                neu_sel    = 1'b1;
                state_next = H1_WAIT;
            end
            H1_WAIT: begin
                neu_sel = 1'b1;
                if (neu_done)      state_next = OUT_WAIT;
                else if (wait_hit) state_next = RESULT;
            end
            OUT_WAIT: begin
                neu_sel = 1'b1;
                if (out_hit) state_next = RESULT;
            end
            RESULT: begin
                neu_sel   = h1_reached;
                rez_valid = 1'b1;
                if (rez_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 16'd0;
            h1_reached   <= 1'b0;
            uzorak       <= 80'd0;
            vjerojatnost <= 16'd0;
            mina         <= 1'b0;
            greska       <= 1'b0;
            broj_uzoraka <= BROJ_INIT;
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= 16'd0;
                    h1_reached <= 1'b0;
                end
                H0_START: cnt <= 16'd1;
                H0_WAIT: begin
                    if (neu_done) begin
                        uzorak[79:40] <= neu_izlaz;
                    end else if (wait_hit) begin
                        vjerojatnost <= 16'd0;
                        mina         <= 1'b0;
                        greska       <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                H1_START: begin
                    cnt        <= 16'd1;
                    h1_reached <= 1'b1;
                end
                H1_WAIT: begin
                    if (neu_done) begin
                        uzorak[39:0] <= neu_izlaz;
                        cnt          <= 16'd1;
                    end else if (wait_hit) begin
                        vjerojatnost <= 16'd0;
                        mina         <= 1'b0;
                        greska       <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                OUT_WAIT: begin
                    if (out_hit) begin
                        vjerojatnost <= izlaz;
                        mina         <= (izlaz >= PRAG);
                        greska       <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESULT: begin
                    if (rez_ready) broj_uzoraka <= broj_uzoraka + 16'd1;
                end
                default: cnt <= 16'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mreza_upravljac.sv
// Directed bench for mreza_upravljac.
// Instance a: default parameters (OUT_LAT=2, TIMEOUT=255, PRAG=8000).
// Instance b: OUT_LAT=1, TIMEOUT=4, broj_uzoraka reset value FFFE for the wrap case.

module tb_mreza_upravljac;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_valid, start_ready, neu_start, neu_sel, neu_done;
    logic [39:0] neu_izlaz;
    logic [79:0] uzorak;
    logic [15:0] izlaz, vjerojatnost, broj_uzoraka;
    logic        rez_valid, rez_ready, mina, greska;

    logic        start_valid_b, start_ready_b, neu_start_b, neu_sel_b, neu_done_b;
    logic [39:0] neu_izlaz_b;
    logic [79:0] uzorak_b;
    logic [15:0] izlaz_b, vjerojatnost_b, broj_uzoraka_b;
    logic        rez_valid_b, rez_ready_b, mina_b, greska_b;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    mreza_upravljac dut_a (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .neu_start(neu_start), .neu_sel(neu_sel),
        .neu_done(neu_done), .neu_izlaz(neu_izlaz),
        .uzorak(uzorak), .izlaz(izlaz),
        .rez_valid(rez_valid), .rez_ready(rez_ready),
        .vjerojatnost(vjerojatnost), .mina(mina), .greska(greska),
        .broj_uzoraka(broj_uzoraka)
    );

    mreza_upravljac #(.OUT_LAT(1), .TIMEOUT(4), .PRAG(16'h8000), .BROJ_INIT(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst),
        .start_valid(start_valid_b), .start_ready(start_ready_b),
        .neu_start(neu_start_b), .neu_sel(neu_sel_b),
        .neu_done(neu_done_b), .neu_izlaz(neu_izlaz_b),
        .uzorak(uzorak_b), .izlaz(izlaz_b),
        .rez_valid(rez_valid_b), .rez_ready(rez_ready_b),
        .vjerojatnost(vjerojatnost_b), .mina(mina_b), .greska(greska_b),
        .broj_uzoraka(broj_uzoraka_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in a START cycle. A bogus done during START must be ignored;
    // the real done arrives d cycles after the start pulse.
    task automatic neuron_a(input logic sel, input int d, input logic [39:0] v);
        chk("neu_start_pulse", neu_start, 1'b1);
        chk("neu_sel_start", neu_sel, sel);
        neu_done  = 1'b1;
        neu_izlaz = 40'hDE_ADBE_EF00;
        tick();
        neu_done  = 1'b0;
        neu_izlaz = 40'h0;
        chk("neu_start_drop", neu_start, 1'b0);
        chk("neu_sel_wait", neu_sel, sel);
        for (int i = 1; i < d; i++) tick();
        neu_done  = 1'b1;
        neu_izlaz = v;
        tick();
        neu_done  = 1'b0;
        neu_izlaz = 40'h0;
    endtask

    // Returns cycles from the start handshake cycle to the first rez_valid cycle.
    task automatic classify_a(input int d0, input int d1, input logic [39:0] h0,
                              input logic [39:0] h1, input logic [15:0] iz, output int l);
        izlaz       = iz;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        neuron_a(1'b0, d0, h0);
        chk("uzorak_h0", {40'h0, uzorak[79:40]}, {40'h0, h0});
        neuron_a(1'b1, d1, h1);
        l = 3 + d0 + d1;
        while (rez_valid !== 1'b1 && l < 64) begin
            tick();
            l++;
        end
    endtask

    task automatic accept_a();
        rez_ready = 1'b1;
        tick();
        rez_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0; neu_done = 1'b0; neu_izlaz = 40'h0; izlaz = 16'h0; rez_ready = 1'b0;
        start_valid_b = 1'b0; neu_done_b = 1'b0; neu_izlaz_b = 40'h0; izlaz_b = 16'h0; rez_ready_b = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_start_ready", start_ready, 1'b1);
        chk("rst_neu_start", neu_start, 1'b0);
        chk("rst_neu_sel", neu_sel, 1'b0);
        chk("rst_uzorak", uzorak, 80'h0);
        chk("rst_rez_valid", rez_valid, 1'b0);
        chk("rst_vjer", vjerojatnost, 16'h0);
        chk("rst_mina_greska", {mina, greska}, 2'b00);
        chk("rst_broj", broj_uzoraka, 16'h0);

        // Reference transaction: done 3 cycles after each start, 1+4+4+2 = 11.
        classify_a(3, 3, 40'h11_2233_4455, 40'hAA_BBCC_DDEE, 16'h9000, lat);
        chk("lat_ref", lat, 11);
        chk("uzorak_ref", uzorak, 80'h1122334455AABBCCDDEE);
        chk("vjer_ref", vjerojatnost, 16'h9000);
        chk("mina_ref", mina, 1'b1);
        chk("greska_ref", greska, 1'b0);
        chk("sel_result", neu_sel, 1'b1);

        // Consumer stalls 5 cycles while a new request is offered.
        start_valid = 1'b1;
        izlaz       = 16'h0123;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", rez_valid, 1'b1);
            chk("stall_ready", start_ready, 1'b0);
            chk("stall_out", {vjerojatnost, mina, greska}, {16'h9000, 1'b1, 1'b0});
            chk("stall_broj", broj_uzoraka, 16'h0);
        end
        start_valid = 1'b0;
        accept_a();
        chk("acc1_broj", broj_uzoraka, 16'h1);
        chk("acc1_valid", rez_valid, 1'b0);
        chk("acc1_ready", start_ready, 1'b1);
        chk("acc1_hold", uzorak, 80'h1122334455AABBCCDDEE);

        // Threshold just below PRAG.
        classify_a(1, 2, 40'h01_0203_0405, 40'hF0_E0D0_C0B0, 16'h7FFF, lat);
        chk("lat_7fff", lat, 8);
        chk("uzorak_7fff", uzorak, 80'h0102030405F0E0D0C0B0);
        chk("vjer_7fff", vjerojatnost, 16'h7FFF);
        chk("mina_7fff", mina, 1'b0);
        accept_a();
        chk("acc2_broj", broj_uzoraka, 16'h2);

        // Threshold exactly at PRAG.
        classify_a(2, 1, 40'h00_0000_0001, 40'h80_0000_0000, 16'h8000, lat);
        chk("lat_8000", lat, 8);
        chk("uzorak_8000", uzorak, 80'h00000000018000000000);
        chk("vjer_8000", vjerojatnost, 16'h8000);
        chk("mina_8000", mina, 1'b1);
        accept_a();
        chk("acc3_broj", broj_uzoraka, 16'h3);

        // Reset while waiting on neuron 1.
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        neuron_a(1'b0, 1, 40'h55_5555_5555);
        tick();
        chk("h1wait_sel", neu_sel, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", start_ready, 1'b1);
        chk("mid_rst_sel", {neu_sel, neu_start}, 2'b00);
        chk("mid_rst_uzorak", uzorak, 80'h0);
        chk("mid_rst_out", {vjerojatnost, mina, greska, rez_valid}, 19'h0);
        chk("mid_rst_broj", broj_uzoraka, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", {rez_valid, start_ready, neu_start}, 3'b010);
        end

        // Instance b: timeout in H0_WAIT after its 4th wait cycle.
        chk("b_rst_broj", broj_uzoraka_b, 16'hFFFE);
        izlaz_b       = 16'hFFFF;
        start_valid_b = 1'b1;
        tick();
        start_valid_b = 1'b0;
        lat = 0;
        while (rez_valid_b !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("b_to_lat", lat, 5);
        chk("b_to_greska", greska_b, 1'b1);
        chk("b_to_vjer_mina", {vjerojatnost_b, mina_b}, 17'h0);
        chk("b_to_sel", neu_sel_b, 1'b0);
        rez_ready_b = 1'b1;
        tick();
        rez_ready_b = 1'b0;
        chk("b_acc1_broj", broj_uzoraka_b, 16'hFFFF);
        chk("b_acc1_valid", rez_valid_b, 1'b0);

        // Done on the same cycle the count reaches TIMEOUT is a success.
        izlaz_b       = 16'hC350;
        start_valid_b = 1'b1;
        tick();
        start_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        neu_done_b  = 1'b1;
        neu_izlaz_b = 40'h12_3456_789A;
        tick();
        neu_done_b  = 1'b0;
        chk("b_edge_h1start", {neu_start_b, neu_sel_b, rez_valid_b}, 3'b110);
        tick();
        neu_done_b  = 1'b1;
        neu_izlaz_b = 40'h0F_0F0F_0F0F;
        tick();
        neu_done_b  = 1'b0;
        lat = 0;
        while (rez_valid_b !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("b_edge_outlat", lat, 1);
        chk("b_edge_greska", greska_b, 1'b0);
        chk("b_edge_vjer", vjerojatnost_b, 16'hC350);
        chk("b_edge_mina", mina_b, 1'b1);
        chk("b_edge_uzorak", uzorak_b, 80'h123456789A0F0F0F0F0F);
        rez_ready_b = 1'b1;
        tick();
        rez_ready_b = 1'b0;
        chk("b_wrap_broj", broj_uzoraka_b, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
